// File: rtl/controle_multiciclo_pkg.sv
// Shared constants and output decode for the multi-cycle RV32 control FSM.
package controle_pkg;

  localparam logic [6:0] TipoR  = 7'b0110011;
  localparam logic [6:0] TipoI  = 7'b0000011;
  localparam logic [6:0] TipoS  = 7'b0100011;
  localparam logic [6:0] TipoSB = 7'b1100011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_PC_ANT = 2'b01;
  localparam logic [1:0] SRC_A_REG    = 2'b10;
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_QUATRO = 2'b01;
  localparam logic [1:0] SRC_B_IMED   = 2'b10;

  typedef enum logic [3:0] {
    BUSCA      = 4'd0,
    DECODIFICA = 4'd1,
    CALC_END   = 4'd2,
    LE_MEM     = 4'd3,
    WB_MEM     = 4'd4,
    ESCR_MEM   = 4'd5,
    EXEC_R     = 4'd6,
    WB_R       = 4'd7,
    DESVIO     = 4'd8,
    ERRO       = 4'd9
  } estado_t;

  // Moore part of the outputs; Mealy terms are added in the top.
  typedef struct packed {
    logic       lida;
    logic       escrita;
    logic       instr_ou_dado;
    logic       pc_origem;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       reg_esc;
    logic       mem_mov;
    logic       concluida;
    logic       erro;
  } saida_t;

  function automatic saida_t decodifica(estado_t e);
    saida_t s;
    s = '0;
    case (e)
      BUSCA:      begin s.lida = 1'b1; s.src_a = SRC_A_PC; s.src_b = SRC_B_QUATRO; end
      DECODIFICA: begin s.src_a = SRC_A_PC_ANT; s.src_b = SRC_B_IMED; end
      CALC_END:   begin s.src_a = SRC_A_REG; s.src_b = SRC_B_IMED; end
      LE_MEM:     begin s.lida = 1'b1; s.instr_ou_dado = 1'b1; end
      WB_MEM:     begin s.reg_esc = 1'b1; s.mem_mov = 1'b1; s.concluida = 1'b1; end
      ESCR_MEM:   begin s.escrita = 1'b1; s.instr_ou_dado = 1'b1; end
      EXEC_R:     begin s.src_a = SRC_A_REG; s.src_b = SRC_B_REG; s.alu_op = 2'b10; end
      WB_R:       begin s.reg_esc = 1'b1; s.concluida = 1'b1; end
      DESVIO:     begin
        s.src_a = SRC_A_REG; s.src_b = SRC_B_REG; s.alu_op = 2'b01;
        s.pc_origem = 1'b1; s.concluida = 1'b1;
      end
      ERRO:       s.erro = 1'b1;
      default:    s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Memory ready/valid handshake between the control FSM and the memory.
interface controle_multiciclo_if;
  logic MemPronta;
  logic MemoriaLida;
  logic MemoriaEscrita;
  logic InstrOuDado;

  modport master (input MemPronta, output MemoriaLida, MemoriaEscrita, InstrOuDado);
  modport slave  (output MemPronta, input MemoriaLida, MemoriaEscrita, InstrOuDado);
endinterface

// File: rtl/controle_multiciclo_contador_espera.sv
// Memory wait counter: clear has priority, limite flags the timeout count.
module contador_espera #(
  parameter int LIMITE = 255,
  parameter int LARG   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic habilita,
  output logic limite
);
  logic [LARG-1:0] contagem;

  always_ff @(posedge clock) begin
    if (reset || limpa) contagem <= '0;
    else if (habilita)  contagem <= contagem + LARG'(1);
  end

  assign limite = (contagem == LARG'(LIMITE));
endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle RV32 control FSM: fetch/decode/execute/memory/write-back with memory stall and traps.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int TIMEOUT_MEM  = 255,
  parameter int LARG_TIMEOUT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            Opcode,
  input  logic                  Zero,
  controle_multiciclo_if.master mem,
  output logic                  EscreveIR,
  output logic                  EscrevePC,
  output logic                  PCOrigem,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic                  ALUOp1,
  output logic                  ALUOp0,
  output logic                  RegistradorEsc,
  output logic                  MemoriaMov,
  output logic                  InstrConcluida,
  output logic                  Erro,
  output logic [3:0]            Estado
);
  estado_t estado, prox;
  saida_t  saida_q;
  logic    espera, limite, limpa;

  always_comb begin
    prox   = estado;
    espera = 1'b0;
    case (estado)
      BUSCA: begin
        espera = 1'b1;
        if (mem.MemPronta) prox = DECODIFICA;
      end
      DECODIFICA: begin
        case (Opcode)
          TipoR:        prox = EXEC_R;
          TipoI, TipoS: prox = CALC_END;
          TipoSB:       prox = DESVIO;
          default:      prox = ERRO;
        endcase
      end
      CALC_END: begin
        if (Opcode == TipoI)      prox = LE_MEM;
        else if (Opcode == TipoS) prox = ESCR_MEM;
        else                      prox = ERRO;
      end
      LE_MEM: begin
        espera = 1'b1;
        if (mem.MemPronta) prox = WB_MEM;
      end
      ESCR_MEM: begin
        espera = 1'b1;
        if (mem.MemPronta) prox = BUSCA;
      end
      EXEC_R:               prox = WB_R;
      WB_MEM, WB_R, DESVIO: prox = BUSCA;
      ERRO:                 prox = ERRO;
      default:              prox = ERRO;
    endcase
    // A late MemPronta on the limit cycle still completes the transfer.
    if (espera && !mem.MemPronta && limite) prox = ERRO;
  end

  assign limpa = (espera & mem.MemPronta) | (prox != estado);

  contador_espera #(
    .LIMITE (TIMEOUT_MEM),
    .LARG   (LARG_TIMEOUT)
  ) u_espera (
    .clock    (clock),
    .reset    (reset),
    .limpa    (limpa),
    .habilita (espera & ~mem.MemPronta),
    .limite   (limite)
  );

  // Moore outputs are registered from the next state so they line up with estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= BUSCA;
      saida_q <= decodifica(BUSCA);
    end else begin
      estado  <= prox;
      saida_q <= decodifica(prox);
    end
  end

  assign mem.MemoriaLida    = saida_q.lida & ~reset;
  assign mem.MemoriaEscrita = saida_q.escrita & ~reset;
  assign mem.InstrOuDado    = saida_q.instr_ou_dado;
  assign EscreveIR          = ~reset & (estado == BUSCA) & mem.MemPronta;
  assign EscrevePC          = ~reset & (((estado == BUSCA) & mem.MemPronta) |
                                        ((estado == DESVIO) & Zero));
  assign PCOrigem           = saida_q.pc_origem;
  assign ALUSrcA            = saida_q.src_a;
  assign ALUSrcB            = saida_q.src_b;
  assign ALUOp1             = saida_q.alu_op[1];
  assign ALUOp0             = saida_q.alu_op[0];
  assign RegistradorEsc     = saida_q.reg_esc & ~reset;
  assign MemoriaMov         = saida_q.mem_mov;
  assign InstrConcluida     = ~reset & (saida_q.concluida |
                                        ((estado == ESCR_MEM) & mem.MemPronta));
  assign Erro               = saida_q.erro;
  assign Estado             = estado;
endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed test-plan sequences plus random traffic vs a step-list model.
module tb_controle_multiciclo;
  localparam int TMO = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  logic clock = 1'b0;
  logic reset, Zero;
  logic [6:0] Opcode;
  logic EscreveIR, EscrevePC, PCOrigem, ALUOp1, ALUOp0, RegistradorEsc;
  logic MemoriaMov, InstrConcluida, Erro;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic [3:0] Estado;

  controle_multiciclo_if mif();

  controle_multiciclo #(.TIMEOUT_MEM(TMO), .LARG_TIMEOUT(3)) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem(mif),
    .EscreveIR(EscreveIR), .EscrevePC(EscrevePC), .PCOrigem(PCOrigem),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0),
    .RegistradorEsc(RegistradorEsc), .MemoriaMov(MemoriaMov),
    .InstrConcluida(InstrConcluida), .Erro(Erro), .Estado(Estado)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  // Model: each instruction class is a list of states; memory steps stall on MemPronta.
  function automatic int classe(logic [6:0] op);
    case (op)
      OP_R:    return 1;
      OP_LD:   return 2;
      OP_ST:   return 3;
      OP_BR:   return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int etapa(int c, int p);
    int t[5];
    case (c)
      0:       t = '{0, 1, -1, -1, -1};
      1:       t = '{0, 1, 6, 7, -1};
      2:       t = '{0, 1, 2, 3, 4};
      3:       t = '{0, 1, 2, 5, -1};
      4:       t = '{0, 1, 8, -1, -1};
      default: t = '{0, 1, 9, -1, -1};
    endcase
    return (p < 5) ? t[p] : -1;
  endfunction

  function automatic logic [15:0] esperado(int s, logic mp, logic z, logic rst);
    logic lida, escr, iod, wir, wpc, pco, regw, mov, conc, err;
    logic [1:0] a, b, op;
    {lida, escr, iod, wir, wpc, pco, regw, mov, conc, err} = '0;
    a = 2'b00; b = 2'b00; op = 2'b00;
    case (s)
      0: begin lida = 1'b1; b = 2'b01; wir = mp; wpc = mp; end
      1: begin a = 2'b01; b = 2'b10; end
      2: begin a = 2'b10; b = 2'b10; end
      3: begin lida = 1'b1; iod = 1'b1; end
      4: begin regw = 1'b1; mov = 1'b1; conc = 1'b1; end
      5: begin escr = 1'b1; iod = 1'b1; conc = mp; end
      6: begin a = 2'b10; op = 2'b10; end
      7: begin regw = 1'b1; conc = 1'b1; end
      8: begin a = 2'b10; op = 2'b01; wpc = z; pco = 1'b1; conc = 1'b1; end
      9: err = 1'b1;
      default: ;
    endcase
    if (rst) {lida, escr, wir, wpc, regw, conc} = '0;
    return {lida, escr, iod, wir, wpc, pco, a, b, op, regw, mov, conc, err};
  endfunction

  int ms = 0, pos = 0, cls = 0, wcnt = 0;
  bit iniciado = 1'b0;

  always @(posedge clock) begin : modelo
    int nms, npos, ncls, nw;
    if (reset) begin
      ms <= 0; pos <= 0; cls <= 0; wcnt <= 0; iniciado <= 1'b1;
    end else if (iniciado && ms != 9) begin
      nms = ms; npos = pos; ncls = cls; nw = wcnt;
      if ((ms == 0 || ms == 3 || ms == 5) && !mif.MemPronta) begin
        if (wcnt == TMO) begin nms = 9; nw = 0; end
        else nw = wcnt + 1;
      end else begin
        nw = 0;
        if (ms == 1) ncls = classe(Opcode);
        npos = pos + 1;
        nms = etapa(ncls, npos);
        if (nms < 0) begin npos = 0; ncls = 0; nms = 0; end
      end
      ms <= nms; pos <= npos; cls <= ncls; wcnt <= nw;
    end
  end

  always @(negedge clock) begin
    if (iniciado) begin
      chk("estado", Estado, ms);
      chk("saidas", {mif.MemoriaLida, mif.MemoriaEscrita, mif.InstrOuDado, EscreveIR,
                     EscrevePC, PCOrigem, ALUSrcA, ALUSrcB, ALUOp1, ALUOp0,
                     RegistradorEsc, MemoriaMov, InstrConcluida, Erro},
          esperado(ms, mif.MemPronta, Zero, reset));
      chk("lida_escrita_exclusivas", mif.MemoriaLida & mif.MemoriaEscrita, 0);
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  int q_st[$], q_mp[$];
  int n_conc;
  logic [15:0] m_reg, m_escr, m_pcw;

  task automatic seq(input string nome, input int st[$], input int mp[$],
                     output int nc, output logic [15:0] mr, output logic [15:0] me,
                     output logic [15:0] mw);
    nc = 0; mr = '0; me = '0; mw = '0;
    foreach (st[i]) begin
      mif.MemPronta = (mp[i] != 0);
      @(negedge clock);
      chk(nome, Estado, st[i]);
      if (InstrConcluida) nc++;
      mr[i] = RegistradorEsc; me[i] = mif.MemoriaEscrita; mw[i] = EscrevePC;
      tick();
    end
  endtask

  initial begin
    int stall;
    int r;
    reset = 1'b1; Opcode = '0; Zero = 1'b0; mif.MemPronta = 1'b0;
    tick(); tick();
    @(negedge clock);
    chk("reset_lida_forcada", mif.MemoriaLida, 0);
    chk("reset_estado", Estado, 0);
    chk("reset_erro", Erro, 0);
    tick();
    reset = 1'b0;

    Opcode = OP_R;
    q_st = '{0, 1, 6, 7}; q_mp = '{1, 1, 1, 1};
    seq("r_estados", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    chk("r_conclui_uma_vez", n_conc, 1);
    chk("r_regesc_so_em_7", m_reg, 16'b1000);

    Opcode = OP_LD;
    q_st = '{0, 1, 2, 3, 3, 3, 3, 4}; q_mp = '{1, 1, 1, 0, 0, 0, 1, 1};
    seq("load_estados", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    chk("load_regesc_em_wb", m_reg, 16'h0080);
    chk("load_conclui", n_conc, 1);

    Opcode = OP_BR; Zero = 1'b1;
    q_st = '{0, 1, 8}; q_mp = '{1, 1, 1};
    seq("br1_estados", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    chk("br1_escrevepc", m_pcw, 16'b101);
    Zero = 1'b0;
    seq("br0_estados", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    chk("br0_escrevepc", m_pcw, 16'b001);

    Opcode = OP_ST;
    q_st = '{0, 1, 2, 5}; q_mp = '{1, 1, 1, 1};
    seq("st_estados", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    chk("st_escrita_so_em_5", m_escr, 16'b1000);
    chk("st_conclui", n_conc, 1);

    Opcode = 7'b1111111;
    q_st = '{0, 1, 9, 9, 9}; q_mp = '{1, 1, 1, 1, 1};
    seq("ilegal_estados", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    @(negedge clock);
    chk("ilegal_erro_pegajoso", Erro, 1);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;

    Opcode = OP_R;
    q_st = '{0, 0, 0, 0, 0, 9}; q_mp = '{0, 0, 0, 0, 0, 0};
    seq("timeout_estados", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    reset = 1'b1; tick(); reset = 1'b0;

    q_st = '{0, 0, 0, 0, 0, 1, 6, 7}; q_mp = '{0, 0, 0, 0, 1, 1, 1, 1};
    seq("limite_sem_erro", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    chk("limite_conclui", n_conc, 1);

    Opcode = OP_LD;
    q_st = '{0, 1, 2, 3, 3}; q_mp = '{1, 1, 1, 0, 0};
    seq("rst_ld_estados", q_st, q_mp, n_conc, m_reg, m_escr, m_pcw);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_ld_lida_forcada", mif.MemoriaLida, 0);
    chk("rst_ld_sem_regesc", RegistradorEsc, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ld_estado", Estado, 0);
    chk("rst_ld_contador", dut.u_espera.contagem, 0);
    chk("rst_ld_sem_regesc_depois", RegistradorEsc, 0);

    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) reset = 1'b0;
      else if (ms == 9 || $urandom_range(0, 299) == 0) reset = 1'b1;
      if (ms == 0) begin
        r = $urandom_range(0, 39);
        if (r == 0) Opcode = 7'($urandom);
        else case (r % 4)
          0: Opcode = OP_R;
          1: Opcode = OP_LD;
          2: Opcode = OP_ST;
          default: Opcode = OP_BR;
        endcase
      end
      if (stall > 0) begin
        mif.MemPronta = 1'b0; stall--;
      end else if ($urandom_range(0, 99) < 3) begin
        stall = $urandom_range(3, 6); mif.MemPronta = 1'b0;
      end else mif.MemPronta = ($urandom_range(0, 9) < 6);
      Zero = 1'($urandom_range(0, 1));
    end

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Moore/Mealy control FSM that sequences a multi-cycle version of the RV32 datapath: register file, immediate extender, ALU control and 2:1 muxes.
- Replaces the single-cycle combinational decoder.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Stalls on a ready/valid memory handshake and traps illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT_MEM, 255, max cycles waiting on MemPronta before entering ERRO.
- LARG_TIMEOUT, 8, width of the wait counter; must satisfy 2^LARG_TIMEOUT > TIMEOUT_MEM.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- Opcode  in  7  instruction[6:0] from the instruction register.
- Zero  in  1  ALU zero flag.
- MemPronta  in  1  memory ready; completes the current read/write this cycle.
- MemoriaLida  out  1  memory read request.
- MemoriaEscrita  out  1  memory write request.
- InstrOuDado  out  1  memory address select: 0 = PC, 1 = ALUOut.
- EscreveIR  out  1  load IR and PC_antigo.
- EscrevePC  out  1  load PC.
- PCOrigem  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- ALUSrcA  out  2  ALU A source: 00 = PC, 01 = PC_antigo, 10 = reg A.
- ALUSrcB  out  2  ALU B source: 00 = reg B, 01 = constant 4, 10 = immediate.
- ALUOp1, ALUOp0  out  1 each  to ALUControl; same encoding as today.
- RegistradorEsc  out  1  register file write enable.
- MemoriaMov  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- InstrConcluida  out  1  one-cycle pulse on instruction retire.
- Erro  out  1  sticky error flag.
- Estado  out  4  current state, for debug.

Behaviour:
- Reset is synchronous. On a clock edge with reset = 1: state = BUSCA, wait counter = 0, Erro = 0. While reset = 1, every strobe output is forced to 0 (MemoriaLida, MemoriaEscrita, EscreveIR, EscrevePC, RegistradorEsc, InstrConcluida).
- Reset mid-operation aborts the instruction with no write.
- Outputs are decoded from the state register. Unlisted outputs are 0 in each state.
- Opcode classes: R = 0110011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011.

State encodings and transitions:
- BUSCA (0): MemoriaLida = 1, InstrOuDado = 0, ALUSrcA = 00, ALUSrcB = 01.
  - EscreveIR = EscrevePC = MemPronta (Mealy), PCOrigem = 0.
  - Stays in BUSCA until MemPronta, then goes to DECODIFICA.
- DECODIFICA (1): ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00 (branch target into ALUOut).
  - R goes to EXEC_R; LOAD or STORE goes to CALC_END; BRANCH goes to DESVIO; any other opcode goes to ERRO.
- CALC_END (2): ALUSrcA = 10, ALUSrcB = 10, ALUOp = 00.
  - LOAD goes to LE_MEM; STORE goes to ESCR_MEM.
- LE_MEM (3): MemoriaLida = 1, InstrOuDado = 1. Waits for MemPronta, then goes to WB_MEM.
- WB_MEM (4): RegistradorEsc = 1, MemoriaMov = 1, InstrConcluida = 1. Goes to BUSCA.
- ESCR_MEM (5): MemoriaEscrita = 1, InstrOuDado = 1. On MemPronta: InstrConcluida = 1, goes to BUSCA.
- EXEC_R (6): ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Goes to WB_R.
- WB_R (7): RegistradorEsc = 1, MemoriaMov = 0, InstrConcluida = 1. Goes to BUSCA.
- DESVIO (8): ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01.
  - EscrevePC = Zero, PCOrigem = 1, InstrConcluida = 1. Goes to BUSCA.
- ERRO (9): all strobes 0, Erro = 1. Terminal until reset.

Memory wait counter:
- Counts each cycle spent in BUSCA, LE_MEM or ESCR_MEM with MemPronta = 0.
- Clears on MemPronta and on any state change.
- When the counter equals TIMEOUT_MEM while still waiting, the next state is ERRO.
- MemPronta arriving in the same cycle the limit is hit wins: the transfer completes and there is no error.

Other rules:
- MemPronta is ignored outside the memory states.
- MemoriaLida and MemoriaEscrita are never both 1.
- Latency with zero-wait memory: R = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3. Each memory wait cycle adds 1.
- Unused state encodings 10–15 go to ERRO.

Decomposition:
- Shared package (controle_pkg) holds:
  - opcode constants TipoR, TipoI, TipoS, TipoSB;
  - state encodings;
  - ALUSrcA/ALUSrcB select constants.
- One sub-module, contador_espera: the wait counter with clear, enable and timeout-hit output.

Test Plan:
- R-type: reset, then Opcode = 0110011 with MemPronta held at 1. States run 0,1,6,7,0. RegistradorEsc = 1 only in state 7, InstrConcluida pulses once, 4 cycles total.
- LOAD with wait states: MemPronta low for 3 cycles in state 3. Stays in LE_MEM for 4 cycles, then state 4 with MemoriaMov = 1 and RegistradorEsc = 1. Total 8 cycles.
- BRANCH: Zero = 1 in state 8 gives EscrevePC = 1 and PCOrigem = 1. Repeated with Zero = 0: EscrevePC stays 0 in state 8.
- STORE then illegal opcode 1111111: the store asserts MemoriaEscrita only in state 5. The illegal opcode goes 1 → 9, Erro = 1 and stays set until reset.
- Timeout, TIMEOUT_MEM = 4: MemPronta held at 0 in BUSCA reaches ERRO after 5 cycles. A repeat run with MemPronta rising exactly on the limit cycle gives no error.
- Reset asserted in LE_MEM: the next edge gives state = 0, no RegistradorEsc pulse, counter = 0.
